main: RTL and testbench

MAIN -- requirements
Module: main

---
 rtl/main_pkg.sv | 22 ++
 rtl/main_alu_core.sv | 54 +++++
 rtl/main.sv | 47 ++++
 tb/tb_main.sv | 120 ++++++++++++
 4 files changed

// File: rtl/main_pkg.sv
// Shared opcode map, default datapath width and flag bundle for the ALU.
package main_pkg;

    localparam int BITS_DEF = 8;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
        logic invalid;
    } alu_flags_t;

endpackage

// File: rtl/main_alu_core.sv
// Purely combinational ALU: result and flags for one opcode/operand set.
module alu_core
    import main_pkg::*;
#(
    parameter int BITS = BITS_DEF
) (
    input  logic [5:0]      op_i,
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic [BITS-1:0] res_o,
    output alu_flags_t      flags_o
);

    localparam logic [BITS:0] BITS_W = (BITS+1)'(BITS);

    logic [BITS:0]   sum;
    logic [BITS:0]   diff;
    logic            big_shamt;
    logic [BITS-1:0] res;
    alu_flags_t      flags;

    always_comb begin
        sum       = {1'b0, a_i} + {1'b0, b_i};
        // The extra top bit of the difference is the unsigned borrow.
        diff      = {1'b0, a_i} - {1'b0, b_i};
        big_shamt = ({1'b0, b_i} >= BITS_W);
        res       = '0;
        flags     = '0;
        case (op_i)
            OP_ADD: begin
                res            = sum[BITS-1:0];
                flags.carry    = sum[BITS];
                flags.overflow = (a_i[BITS-1] == b_i[BITS-1]) && (res[BITS-1] != a_i[BITS-1]);
            end
            OP_SUB: begin
                res            = diff[BITS-1:0];
                flags.carry    = diff[BITS];
                flags.overflow = (a_i[BITS-1] != b_i[BITS-1]) && (res[BITS-1] != a_i[BITS-1]);
            end
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_NOR: res = ~(a_i | b_i);
            OP_SRL: res = big_shamt ? '0 : (a_i >> b_i);
            OP_SRA: res = big_shamt ? {BITS{a_i[BITS-1]}} : BITS'($signed(a_i) >>> b_i);
            default: flags.invalid = 1'b1;
        endcase
        flags.zero = (res == '0);
    end

    assign res_o   = res;
    assign flags_o = flags;

endmodule

// File: rtl/main.sv
// Registered ALU: one-cycle latency, async active-high reset to the zero result.
module main
    import main_pkg::*;
#(
    parameter int BITS = BITS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      Op,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    output logic [BITS-1:0] out,
    output logic            carry,
    output logic            zero,
    output logic            overflow,
    output logic            invalid
);

    logic [BITS-1:0] out_d, out_q;
    alu_flags_t      flags_d, flags_q;

    alu_core #(.BITS(BITS)) u_core (
        .op_i   (Op),
        .a_i    (A),
        .b_i    (B),
        .res_o  (out_d),
        .flags_o(flags_d)
    );

    // Reset state is a cleared result, so zero is the only flag that comes up set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            flags_q <= '{carry: 1'b0, zero: 1'b1, overflow: 1'b0, invalid: 1'b0};
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign out      = out_q;
    assign carry    = flags_q.carry;
    assign zero     = flags_q.zero;
    assign overflow = flags_q.overflow;
    assign invalid  = flags_q.invalid;

endmodule

// File: tb/tb_main.sv
// Directed-vector bench for the registered ALU with hand-computed expectations.
module tb_main;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [7:0] A, B;
    logic [7:0] out;
    logic       carry, zero, overflow, invalid;

    int n_chk = 0;
    int n_err = 0;

    main #(.BITS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .out     (out),
        .carry   (carry),
        .zero    (zero),
        .overflow(overflow),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {carry, zero, overflow, invalid}.
    task automatic chk_all(input string tag, input logic [7:0] e_out, input logic [3:0] e_fl);
        chk({tag, ".out"}, {24'h0, out}, {24'h0, e_out});
        chk({tag, ".flags"}, {28'h0, carry, zero, overflow, invalid}, {28'h0, e_fl});
    endtask

    // Drive away from the edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        Op = op; A = a; B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        Op = 6'b100000; A = 8'h82; B = 8'h01;
        #1;
        chk_all("reset_async", 8'h00, 4'b0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset_hold", 8'h00, 4'b0100);
        reset = 1'b0;

        // Sweep with A=0x82, B=0x01
        apply(6'b100000, 8'h82, 8'h01); chk_all("add", 8'h83, 4'b0000);
        apply(6'b100010, 8'h82, 8'h01); chk_all("sub", 8'h81, 4'b0000);
        apply(6'b100100, 8'h82, 8'h01); chk_all("and", 8'h00, 4'b0100);
        apply(6'b100101, 8'h82, 8'h01); chk_all("or",  8'h83, 4'b0000);
        apply(6'b100110, 8'h82, 8'h01); chk_all("xor", 8'h83, 4'b0000);
        apply(6'b000011, 8'h82, 8'h01); chk_all("sra", 8'hC1, 4'b0000);
        apply(6'b000010, 8'h82, 8'h01); chk_all("srl", 8'h41, 4'b0000);
        apply(6'b100111, 8'h82, 8'h01); chk_all("nor", 8'h7C, 4'b0000);

        // Arithmetic boundaries
        apply(6'b100000, 8'hFF, 8'h01); chk_all("add_carry", 8'h00, 4'b1100);
        apply(6'b100000, 8'h7F, 8'h01); chk_all("add_ovf",   8'h80, 4'b0010);
        apply(6'b100010, 8'h00, 8'h01); chk_all("sub_borrow", 8'hFF, 4'b1000);
        apply(6'b100010, 8'h80, 8'h01); chk_all("sub_ovf",   8'h7F, 4'b0010);
        apply(6'b100010, 8'h01, 8'h01); chk_all("sub_eq",    8'h00, 4'b0100);

        // Shift-amount boundaries
        apply(6'b000011, 8'h82, 8'd9); chk_all("sra_big",  8'hFF, 4'b0000);
        apply(6'b000011, 8'h42, 8'd8); chk_all("sra_bigp", 8'h00, 4'b0100);
        apply(6'b000010, 8'h82, 8'd8); chk_all("srl_big",  8'h00, 4'b0100);
        apply(6'b000010, 8'h82, 8'd7); chk_all("srl_7",    8'h01, 4'b0000);
        apply(6'b000011, 8'h82, 8'd7); chk_all("sra_7",    8'hFF, 4'b0000);

        // Unsupported opcode, then recovery
        apply(6'b111111, 8'h82, 8'h01); chk_all("invalid", 8'h00, 4'b0101);
        apply(6'b100101, 8'h0F, 8'hF0); chk_all("after_inv", 8'hFF, 4'b0000);

        // Inputs changing between edges must not show until the next edge
        Op = 6'b100100; A = 8'h00; B = 8'h00;
        #2;
        chk_all("mid_cycle_hold", 8'hFF, 4'b0000);
        @(posedge clk); #1;
        chk_all("mid_cycle_next", 8'h00, 4'b0100);

        // Reset between edges after a nonzero result
        apply(6'b100000, 8'h82, 8'h01); chk_all("pre_reset", 8'h83, 4'b0000);
        Op = 6'b100110; A = 8'h55; B = 8'h0F;
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid_reset", 8'h00, 4'b0100);
        @(posedge clk); #1;
        chk_all("reset_discard", 8'h00, 4'b0100);
        reset = 1'b0;
        #1;
        chk_all("release_wait", 8'h00, 4'b0100);
        @(posedge clk); #1;
        chk_all("release_first", 8'h5A, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
